// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, jump redirects,
// data-memory waits with timeout, and an external freeze handshake.
module pipe_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk_100MHz,
   input  logic                   arst,
   input  logic                   ld_use_i,
   input  logic                   jump_ena_i,
   input  logic [31:0]            jump_addr_i,
   input  logic                   mem_req_i,
   input  logic                   mem_ack_i,
   input  logic                   sys_hold_req_i,
   output logic                   sys_hold_ack_o,
   output logic                   hold_pc_o,
   output logic                   hold_if_id_o,
   output logic                   hold_id_ex_o,
   output logic                   hold_ex_mem_o,
   output logic                   hold_mem_wb_o,
   output logic                   flush_if_id_o,
   output logic                   flush_id_ex_o,
   output logic                   pc_redirect_o,
   output logic [31:0]            pc_redirect_addr_o,
   output logic                   mem_err_o,
   output logic [1:0]             state_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [WAIT_W-1:0]      wait_nxt;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   mem_err;
   logic                   tmo;
   logic                   mem_stall;

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
      return (&v) ? v : v + STALL_CNT_W'(1);
   endfunction

   // Last permitted wait cycle: the stall is dropped so mem_wb captures whatever is there.
   assign tmo       = (state == MEMWAIT) && (wait_cnt == WAIT_LAST);
   assign mem_stall = mem_req_i & ~mem_ack_i & ~tmo;

   always_ff @(posedge clk_100MHz or posedge arst) begin
      if (arst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (tmo)
            mem_err <= 1'b1;
         if (hold_pc_o)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_nxt = MEMWAIT;
               wait_nxt  = '0;
            end else if (sys_hold_req_i) begin
               state_nxt = HOLD;
            end
         end
         MEMWAIT: begin
            if (mem_stall) begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end else begin
               wait_nxt  = '0;
               state_nxt = sys_hold_req_i ? HOLD : RUN;
            end
         end
         HOLD: begin
            if (!sys_hold_req_i)
               state_nxt = RUN;
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      hold_pc_o          = 1'b0;
      hold_if_id_o       = 1'b0;
      hold_id_ex_o       = 1'b0;
      hold_ex_mem_o      = 1'b0;
      hold_mem_wb_o      = 1'b0;
      flush_if_id_o      = 1'b0;
      flush_id_ex_o      = 1'b0;
      pc_redirect_o      = 1'b0;
      pc_redirect_addr_o = '0;
      sys_hold_ack_o     = 1'b0;
      if (arst || mem_stall || (state == HOLD) || ((state == RUN) && sys_hold_req_i)) begin
         hold_pc_o      = 1'b1;
         hold_if_id_o   = 1'b1;
         hold_id_ex_o   = 1'b1;
         hold_ex_mem_o  = 1'b1;
         hold_mem_wb_o  = 1'b1;
         sys_hold_ack_o = ~arst && (state == HOLD);
      end else if ((state == RUN) && jump_ena_i) begin
         pc_redirect_o      = 1'b1;
         pc_redirect_addr_o = jump_addr_i;
         flush_if_id_o      = 1'b1;
         flush_id_ex_o      = 1'b1;
      end else if ((state == RUN) && ld_use_i) begin
         // Freeze fetch/decode and slip one bubble into EX; older stages drain.
         hold_pc_o     = 1'b1;
         hold_if_id_o  = 1'b1;
         flush_id_ex_o = 1'b1;
      end
   end

   assign state_o     = state;
   assign mem_err_o   = mem_err;
   assign stall_cnt_o = stall_cnt;

endmodule
